// File: rtl/aurora_bus_pkg.sv
// Shared definitions for the Aurora local-bus pattern master: FSM encoding, default widths,
// and handshake bit positions as laid out on the bus debug tap.
package aurora_bus_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Bit positions of the handshake lines in the debug bus capture word
   localparam int HS_STB   = 0;
   localparam int HS_WE    = 1;
   localparam int HS_M_RDY = 2;
   localparam int HS_ACK   = 3;
   localparam int HS_S_RDY = 4;
   localparam int HS_ABORT = 5;
   localparam int HS_W     = 6;

endpackage

// File: rtl/aurora_bus_if.sv
// Aurora local-bus handshake and data signals with initiator/target views.
interface aurora_bus_if #(
   parameter int DATA_W = 32
);
   logic              stb;
   logic              we;
   logic              m_rdy;
   logic [DATA_W-1:0] dat_o;
   logic              ack;
   logic              s_rdy;
   logic [DATA_W-1:0] dat_i;
   logic              abort;

   modport master (
      output stb, we, m_rdy, dat_o,
      input  ack, s_rdy, dat_i, abort
   );

   modport slave (
      input  stb, we, m_rdy, dat_o,
      output ack, s_rdy, dat_i, abort
   );
endinterface

// File: rtl/aurora_bus_rd_checker.sv
// Read-data checker: compares each accepted read word against the incrementing pattern and
// against the previously accepted word, with saturating error and duplicate counters.
module aurora_bus_rd_checker #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [DATA_W-1:0] base,
   input  logic              beat,
   input  logic              first,
   input  logic [DATA_W-1:0] dat_i,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  dup_cnt
);

   logic [DATA_W-1:0] exp_q, exp_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [CNT_W-1:0]  dup_q, dup_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q  <= '0;
         prev_q <= '0;
         err_q  <= '0;
         dup_q  <= '0;
      end else begin
         exp_q  <= exp_d;
         prev_q <= prev_d;
         err_q  <= err_d;
         dup_q  <= dup_d;
      end
   end

   always_comb begin
      exp_d  = exp_q;
      prev_d = prev_q;
      err_d  = err_q;
      dup_d  = dup_q;
      if (clear) begin
         exp_d = base;
         err_d = '0;
         dup_d = '0;
      end else if (beat) begin
         // Expected word advances on every beat so one bad word does not cascade
         exp_d  = exp_q + DATA_W'(1);
         prev_d = dat_i;
         if (dat_i != exp_q && err_q != '1)
            err_d = err_q + CNT_W'(1);
         if (!first && dat_i == prev_q && dup_q != '1)
            dup_d = dup_q + CNT_W'(1);
      end
   end

   assign err_cnt = err_q;
   assign dup_cnt = dup_q;

endmodule

// File: rtl/aurora_bus_pattern_master.sv
// Aurora local-bus initiator: writes incrementing-pattern bursts and checks read bursts,
// with abort handling and a no-beat watchdog.
//
//   state    | meaning
//   ST_IDLE  | waiting for req_w/req_r with nonzero burst_len
//   ST_WRITE | stb/we/m_rdy high, pattern word on dat_o, beat on ack
//   ST_READ  | stb high, beat on s_rdy, read words checked
//   ST_DONE  | one-cycle done pulse, then back to idle
module aurora_bus_pattern_master
   import aurora_bus_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int LEN_W       = 16,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_w,
   input  logic              req_r,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic [DATA_W-1:0] base_pattern,
   aurora_bus_if.master      bus,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              timed_out,
   output logic [LEN_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  dup_cnt
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [LEN_W-1:0]  beat_inc;
   logic [DATA_W-1:0] pat_q, pat_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              aborted_q, aborted_d;
   logic              timed_out_q, timed_out_d;
   logic              stb_q, stb_d;
   logic              we_q, we_d;
   logic              m_rdy_q, m_rdy_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              start;
   logic              beat;
   logic              rd_beat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         pat_q       <= '0;
         wd_q        <= '0;
         aborted_q   <= 1'b0;
         timed_out_q <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         m_rdy_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         pat_q       <= pat_d;
         wd_q        <= wd_d;
         aborted_q   <= aborted_d;
         timed_out_q <= timed_out_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         m_rdy_q     <= m_rdy_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign beat_inc = beat_cnt_q + LEN_W'(1);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      pat_d       = pat_q;
      wd_d        = wd_q;
      aborted_d   = aborted_q;
      timed_out_d = timed_out_q;
      start       = 1'b0;
      beat        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((req_w || req_r) && burst_len != '0) begin
               start       = 1'b1;
               state_d     = req_w ? ST_WRITE : ST_READ;
               len_d       = burst_len;
               pat_d       = base_pattern;
               beat_cnt_d  = '0;
               wd_d        = WD_LOAD;
               aborted_d   = 1'b0;
               timed_out_d = 1'b0;
            end
         end
         ST_WRITE, ST_READ: begin
            beat = (state_q == ST_WRITE) ? bus.ack : bus.s_rdy;
            // Abort outranks both a coincident beat and a watchdog expiry
            if (bus.abort) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else if (beat) begin
               beat_cnt_d = beat_inc;
               wd_d       = WD_LOAD;
               if (state_q == ST_WRITE)
                  pat_d = pat_q + DATA_W'(1);
               if (beat_inc == len_q)
                  state_d = ST_DONE;
            end else if (wd_q == WD_W'(1)) begin
               state_d     = ST_DONE;
               timed_out_d = 1'b1;
            end else begin
               wd_d = wd_q - WD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      stb_d   = (state_d == ST_WRITE) || (state_d == ST_READ);
      we_d    = (state_d == ST_WRITE);
      m_rdy_d = (state_d == ST_WRITE);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   assign rd_beat = (state_q == ST_READ) && bus.s_rdy && !bus.abort;

   aurora_bus_rd_checker #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_rd_checker (
      .clk     (clk),
      .rst     (rst),
      .clear   (start),
      .base    (base_pattern),
      .beat    (rd_beat),
      .first   (beat_cnt_q == '0),
      .dat_i   (bus.dat_i),
      .err_cnt (err_cnt),
      .dup_cnt (dup_cnt)
   );

   assign bus.stb   = stb_q;
   assign bus.we    = we_q;
   assign bus.m_rdy = m_rdy_q;
   assign bus.dat_o = pat_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign aborted   = aborted_q;
   assign timed_out = timed_out_q;
   assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_aurora_bus_pattern_master.sv
// Directed bench for aurora_bus_pattern_master: write/read bursts, abort, timeout,
// request arbitration and asynchronous reset mid-burst.
module tb_aurora_bus_pattern_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_w = 1'b0;
   logic        req_r = 1'b0;
   logic [15:0] burst_len = '0;
   logic [31:0] base_pattern = '0;
   logic        busy, done, aborted, timed_out;
   logic [15:0] beat_cnt, err_cnt, dup_cnt;

   int tests = 0;
   int fails = 0;

   aurora_bus_if #(.DATA_W(32)) bus ();

   aurora_bus_pattern_master #(
      .DATA_W      (32),
      .LEN_W       (16),
      .CNT_W       (16),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_w        (req_w),
      .req_r        (req_r),
      .burst_len    (burst_len),
      .base_pattern (base_pattern),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .timed_out    (timed_out),
      .beat_cnt     (beat_cnt),
      .err_cnt      (err_cnt),
      .dup_cnt      (dup_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.ack   = 1'b0;
      bus.s_rdy = 1'b0;
      bus.dat_i = '0;
      bus.abort = 1'b0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      check("rst_stb", 32'(bus.stb), 32'd0);
      check("rst_dat_o", bus.dat_o, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_beat_cnt", 32'(beat_cnt), 32'd0);

      // 1: write burst len 4 from 0xFE, ack always high
      req_w = 1'b1; burst_len = 16'd4; base_pattern = 32'h0000_00FE; bus.ack = 1'b1;
      tick();
      req_w = 1'b0;
      check("t1_stb", 32'(bus.stb), 32'd1);
      check("t1_we", 32'(bus.we), 32'd1);
      check("t1_m_rdy", 32'(bus.m_rdy), 32'd1);
      check("t1_dat0", bus.dat_o, 32'h0000_00FE);
      tick();
      check("t1_dat1", bus.dat_o, 32'h0000_00FF);
      tick();
      check("t1_dat2", bus.dat_o, 32'h0000_0100);
      tick();
      check("t1_dat3", bus.dat_o, 32'h0000_0101);
      check("t1_done_low", 32'(done), 32'd0);
      tick();
      check("t1_done", 32'(done), 32'd1);
      check("t1_stb_off", 32'(bus.stb), 32'd0);
      check("t1_beats", 32'(beat_cnt), 32'd4);
      bus.ack = 1'b0;
      tick();
      check("t1_done_1cyc", 32'(done), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);

      // 2: read burst len 3 from 0x10, data 10,11,11
      req_r = 1'b1; burst_len = 16'd3; base_pattern = 32'h10;
      tick();
      req_r = 1'b0;
      check("t2_stb", 32'(bus.stb), 32'd1);
      check("t2_we", 32'(bus.we), 32'd0);
      check("t2_m_rdy", 32'(bus.m_rdy), 32'd0);
      bus.s_rdy = 1'b1; bus.dat_i = 32'h10;
      tick();
      bus.dat_i = 32'h11;
      tick();
      bus.dat_i = 32'h11;
      tick();
      bus.s_rdy = 1'b0;
      check("t2_done", 32'(done), 32'd1);
      check("t2_err", 32'(err_cnt), 32'd1);
      check("t2_dup", 32'(dup_cnt), 32'd1);
      check("t2_beats", 32'(beat_cnt), 32'd3);
      tick();

      // 3: write len 5, abort coincident with third ack
      req_w = 1'b1; burst_len = 16'd5; base_pattern = 32'h0; bus.ack = 1'b1;
      tick();
      req_w = 1'b0;
      check("t3_err_clr", 32'(err_cnt), 32'd0);
      check("t3_dup_clr", 32'(dup_cnt), 32'd0);
      tick();
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0; bus.ack = 1'b0;
      check("t3_beats", 32'(beat_cnt), 32'd2);
      check("t3_aborted", 32'(aborted), 32'd1);
      check("t3_done", 32'(done), 32'd1);
      check("t3_stb_off", 32'(bus.stb), 32'd0);
      check("t3_timed_out", 32'(timed_out), 32'd0);
      tick();
      check("t3_aborted_sticky", 32'(aborted), 32'd1);

      // 4: read len 2, s_rdy never -> timeout after 8 cycles without a beat
      req_r = 1'b1; burst_len = 16'd2; base_pattern = 32'h0;
      tick();
      req_r = 1'b0;
      check("t4_aborted_clr", 32'(aborted), 32'd0);
      for (int i = 0; i < 7; i++) tick();
      check("t4_stb_7", 32'(bus.stb), 32'd1);
      check("t4_to_early", 32'(timed_out), 32'd0);
      tick();
      check("t4_done", 32'(done), 32'd1);
      check("t4_timed_out", 32'(timed_out), 32'd1);
      check("t4_stb_off", 32'(bus.stb), 32'd0);
      check("t4_beats", 32'(beat_cnt), 32'd0);
      tick();

      // 5: req_w and req_r together -> write; request during burst not serviced
      req_w = 1'b1; req_r = 1'b1; burst_len = 16'd2; base_pattern = 32'h55;
      tick();
      req_w = 1'b0;
      check("t5_we", 32'(bus.we), 32'd1);
      check("t5_dat", bus.dat_o, 32'h55);
      tick();
      req_r = 1'b0; bus.ack = 1'b1;
      tick();
      tick();
      bus.ack = 1'b0;
      check("t5_done", 32'(done), 32'd1);
      check("t5_beats", 32'(beat_cnt), 32'd2);
      tick();
      tick();
      check("t5_no_queue_stb", 32'(bus.stb), 32'd0);
      check("t5_no_queue_busy", 32'(busy), 32'd0);
      // Zero-length request ignored entirely
      req_w = 1'b1; burst_len = 16'd0;
      tick();
      req_w = 1'b0;
      check("t5_len0_stb", 32'(bus.stb), 32'd0);
      tick();
      check("t5_len0_done", 32'(done), 32'd0);

      // 6: write from 0xFFFF_FFFF wraps to 0; async reset mid-burst
      req_w = 1'b1; burst_len = 16'd2; base_pattern = 32'hFFFF_FFFF; bus.ack = 1'b1;
      tick();
      req_w = 1'b0;
      check("t6_dat0", bus.dat_o, 32'hFFFF_FFFF);
      tick();
      check("t6_wrap", bus.dat_o, 32'h0);
      check("t6_beat1", 32'(beat_cnt), 32'd1);
      check("t6_stb_pre", 32'(bus.stb), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_stb", 32'(bus.stb), 32'd0);
      check("t6_rst_we", 32'(bus.we), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_beats", 32'(beat_cnt), 32'd0);
      check("t6_rst_dat", bus.dat_o, 32'd0);
      bus.ack = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("t6_post_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
